// File: rtl/four_bit_serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// four_bit_serial_sub_pkg
// Shared definitions for the 4-bit serial subtractor demo block.
// The only thing shared is the encoding of the 2-bit 'sel' mode bus.
// The shift registers and the top-level carry flop must agree on this
// encoding, so it lives here rather than being repeated in each file.
// ---------------------------------------------------------------------------
package four_bit_serial_sub_pkg;

   // Mode encoding driven on 'sel' by whatever sequencer owns this datapath
   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage

// File: rtl/shift_reg_4.sv
// ---------------------------------------------------------------------------
// shift_reg_4
// 4-bit universal shift register. The serial subtractor instantiates it twice:
// once for the minuend/difference (A) and once for the subtrahend (B).
//
// Ports
//   clk        in  1  rising-edge clock
//   rstn       in  1  asynchronous active-low reset, clears the register
//   sel        in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
//   serInRight in  1  bit entering the MSB on a right shift
//   serInLeft  in  1  bit entering the LSB on a left shift
//   parIn      in  4  value captured on a parallel load
//   parOut     out 4  current register contents
// ---------------------------------------------------------------------------
module shift_reg_4
   import four_bit_serial_sub_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] sel,
   input  logic       serInRight,
   input  logic       serInLeft,
   input  logic [3:0] parIn,
   output logic [3:0] parOut
);

   // Register update. A right shift moves data toward bit 0 so that the LSB
   // is consumed first, and the new bit enters at the MSB. A left shift is the
   // mirror image and is only used for maintenance. Any code other than the
   // three active modes leaves the contents untouched.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         parOut <= 4'b0000;
      end else begin
         case (sel)
            SEL_SHR:  parOut <= {serInRight, parOut[3:1]};
            SEL_SHL:  parOut <= {parOut[2:0], serInLeft};
            SEL_LOAD: parOut <= parIn;
            default:  parOut <= parOut;
         endcase
      end
   end

endmodule

// File: rtl/four_bit_serial_sub.sv
// ---------------------------------------------------------------------------
// four_bit_serial_sub
// Serial subtractor that computes A - B one bit per clock, LSB first. The
// design has these parts:
//   - two 4-bit universal shift registers, A and B
//   - a full adder that adds A, the inverse of B and the carry
//   - a JK flip-flop that holds the carry.
// The difference shifts back into register A. When Q is 1 at the end of a
// subtraction, no borrow occurred, which means A >= B. All internals are
// brought out so the block can be watched as a datapath demo.
//
// Parameters
//   A_LOAD  value loaded into A on a parallel load
//   B_LOAD  value loaded into B on a parallel load
//
// Ports
//   clk              in  1  rising-edge clock
//   rstn             in  1  asynchronous active-low reset
//   SI               in  1  serial input that feeds register B, and A on left shifts
//   sel              in  2  00 hold, 01 shift right, 10 shift left, 11 load
//   shift_reg_A_out  out 4  register A (minuend, then difference)
//   shift_reg_B_out  out 4  register B (subtrahend)
//   Q                out 1  carry flip-flop (1 = no borrow)
//   Sum              out 1  full-adder difference bit
//   J                out 1  JK set input
//   K                out 1  JK reset input
// ---------------------------------------------------------------------------
module four_bit_serial_sub
   import four_bit_serial_sub_pkg::*;
#(
   parameter logic [3:0] A_LOAD = 4'd9,
   parameter logic [3:0] B_LOAD = 4'd5
)
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       SI,
   input  logic [1:0] sel,
   output logic [3:0] shift_reg_A_out,
   output logic [3:0] shift_reg_B_out,
   output logic       Q,
   output logic       Sum,
   output logic       J,
   output logic       K
);

   logic aBit;
   logic bBit;

   assign aBit = shift_reg_A_out[0];
   assign bBit = shift_reg_B_out[0];

   // Full adder on a, ~b and the carry. Adding the inverse of B with a carry
   // seeded to 1 at load time forms the two's complement of B.
   // The JK flop implements the carry-out of the full adder:
   //   - a=1, ~b=1: carry out is always 1 (J).
   //   - a=0, ~b=0: carry out is always 0 (K).
   //   - otherwise: carry out equals the old carry (hold).
   // J and K can never both be 1 because they need opposite values of a.
   always_comb begin
      Sum = aBit ^ ~bBit ^ Q;
      J   = aBit & ~bBit;
      K   = ~aBit & bBit;
   end

   // Register A. On a right shift it takes the difference bit in at its MSB,
   // so after four shifts it holds the complete result.
   shift_reg_4 regA (
      .clk        (clk),
      .rstn       (rstn),
      .sel        (sel),
      .serInRight (Sum),
      .serInLeft  (SI),
      .parIn      (A_LOAD),
      .parOut     (shift_reg_A_out)
   );

   // Register B. The serial input feeds it in both shift directions.
   shift_reg_4 regB (
      .clk        (clk),
      .rstn       (rstn),
      .sel        (sel),
      .serInRight (SI),
      .serInLeft  (SI),
      .parIn      (B_LOAD),
      .parOut     (shift_reg_B_out)
   );

   // Carry/borrow flop. A load seeds it to 1, and a right shift applies the
   // JK rule. In every other mode, including left shift, it holds. On reset
   // it goes to 1, the same value a load gives it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         Q <= 1'b1;
      end else begin
         case (sel)
            SEL_LOAD: Q <= 1'b1;
            SEL_SHR: begin
               case ({J, K})
                  2'b10:   Q <= 1'b1;
                  2'b01:   Q <= 1'b0;
                  default: Q <= Q;
               endcase
            end
            default:  Q <= Q;
         endcase
      end
   end

endmodule

// File: tb/tb_four_bit_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_four_bit_serial_sub
// Scoreboard bench for the serial subtractor. Each driven cycle advances an
// arithmetic model of the registers. The expected snapshot after the edge is
// queued, and a monitor compares it against the DUT just after every rising
// edge. A second instance with loads 3/5 exercises the borrow case.
// ---------------------------------------------------------------------------
module tb_four_bit_serial_sub;
   import four_bit_serial_sub_pkg::*;

   typedef struct {
      string      tag;
      logic [3:0] a;
      logic [3:0] b;
      logic       q;
      logic       sum;
      logic       j;
      logic       k;
   } snap_t;

   logic       clk;
   logic       rstn;
   logic       SI;
   logic [1:0] sel;
   logic [3:0] aOut, bOut;
   logic       qOut, sumOut, jOut, kOut;

   logic       si2;
   logic [1:0] sel2;
   logic [3:0] aOut2, bOut2;
   logic       qOut2, sumOut2, jOut2, kOut2;

   snap_t expQ[$];
   int    checks;
   int    errors;

   // Model state: plain integers holding the register values and the carry
   int    mA, mB, mQ;

   four_bit_serial_sub #(.A_LOAD(4'd9), .B_LOAD(4'd5)) dut (
      .clk(clk), .rstn(rstn), .SI(SI), .sel(sel),
      .shift_reg_A_out(aOut), .shift_reg_B_out(bOut),
      .Q(qOut), .Sum(sumOut), .J(jOut), .K(kOut)
   );

   four_bit_serial_sub #(.A_LOAD(4'd3), .B_LOAD(4'd5)) dut2 (
      .clk(clk), .rstn(rstn), .SI(si2), .sel(sel2),
      .shift_reg_A_out(aOut2), .shift_reg_B_out(bOut2),
      .Q(qOut2), .Sum(sumOut2), .J(jOut2), .K(kOut2)
   );

   // Free-running clock, 10-time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something upstream wedges
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Build the expected observable outputs from the model state. Sum is the
   // low bit of a + (1-b) + carry. J and K are set exactly when the carry-out
   // is forced to 1 or to 0 regardless of the incoming carry.
   function automatic snap_t modelSnap(input string tag);
      snap_t s;
      int    t;
      int    a0, b0;
      a0    = mA % 2;
      b0    = mB % 2;
      t     = a0 + (1 - b0) + mQ;
      s.tag = tag;
      s.a   = 4'(mA);
      s.b   = 4'(mB);
      s.q   = (mQ != 0);
      s.sum = (t % 2) != 0;
      s.j   = (a0 == 1) && (b0 == 0);
      s.k   = (a0 == 0) && (b0 == 1);
      return s;
   endfunction

   // Advance the model by one clock in the given mode
   task automatic modelStep(input logic [1:0] s, input logic si);
      int t;
      case (s)
         SEL_LOAD: begin mA = 9; mB = 5; mQ = 1; end
         SEL_SHR: begin
            t  = (mA % 2) + (1 - (mB % 2)) + mQ;
            mA = (mA / 2) + (t % 2) * 8;
            mB = (mB / 2) + int'(si) * 8;
            mQ = t / 2;
         end
         SEL_SHL: begin
            mA = (mA * 2 + int'(si)) % 16;
            mB = (mB * 2 + int'(si)) % 16;
         end
         default: ;
      endcase
   endtask

   task automatic modelReset();
      mA = 0;
      mB = 0;
      mQ = 1;
   endtask

   // Compare one expected snapshot against the live outputs of the main DUT
   task automatic checkOutput(input snap_t e);
      checks++;
      if (aOut !== e.a || bOut !== e.b || qOut !== e.q ||
          sumOut !== e.sum || jOut !== e.j || kOut !== e.k) begin
         errors++;
         $display("[TB] FAIL %s: got A=%b B=%b Q=%b Sum=%b J=%b K=%b expected A=%b B=%b Q=%b Sum=%b J=%b K=%b",
                  e.tag, aOut, bOut, qOut, sumOut, jOut, kOut,
                  e.a, e.b, e.q, e.sum, e.j, e.k);
      end
   endtask

   task automatic checkValue(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Drive one cycle of stimulus on the falling edge and queue what the DUT
   // must show just after the following rising edge
   task automatic applyStimulus(input logic [1:0] s, input logic si, input string tag);
      @(negedge clk);
      sel = s;
      SI  = si;
      modelStep(s, si);
      expQ.push_back(modelSnap(tag));
   endtask

   // Monitor: just after each rising edge, pop and compare any pending entry
   always @(posedge clk) begin : monitor
      snap_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput(e);
      end
   end

   // Main stimulus sequence
   initial begin : stimulus
      logic [3:0] expB2;
      int         r;
      logic [1:0] rs;

      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      SI     = 1'b0;
      sel    = SEL_HOLD;
      si2    = 1'b0;
      sel2   = SEL_HOLD;
      expB2  = 4'b0000;
      modelReset();

      // Reset state
      #12;
      checkOutput(modelSnap("reset"));
      @(negedge clk);
      rstn = 1'b1;

      // Load 9/5 and shift four times with SI=0; the result is 4, with no borrow
      applyStimulus(SEL_LOAD, 1'b0, "load");
      for (int i = 0; i < 4; i++) applyStimulus(SEL_SHR, 1'b0, "shr9m5");
      applyStimulus(SEL_HOLD, 1'b0, "after4");

      // Load, then hold for three cycles
      applyStimulus(SEL_LOAD, 1'b0, "load2");
      for (int i = 0; i < 3; i++) applyStimulus(SEL_HOLD, 1'b1, "hold");

      // Load, then one left shift with SI=1
      applyStimulus(SEL_LOAD, 1'b0, "load3");
      applyStimulus(SEL_SHL, 1'b1, "shl");
      applyStimulus(SEL_HOLD, 1'b0, "postshl");

      // Load, shift twice, then pulse reset between edges
      applyStimulus(SEL_LOAD, 1'b0, "load4");
      applyStimulus(SEL_SHR, 1'b1, "shrA");
      applyStimulus(SEL_SHR, 1'b0, "shrB");
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      modelReset();
      checkOutput(modelSnap("midreset"));
      @(negedge clk);
      sel  = SEL_HOLD;
      rstn = 1'b1;

      // Random traffic with occasional reloads
      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      rs = SEL_LOAD;
         else if (r < 6)  rs = SEL_SHR;
         else if (r < 8)  rs = SEL_SHL;
         else             rs = SEL_HOLD;
         applyStimulus(rs, 1'($urandom_range(0, 1)), "random");
      end
      applyStimulus(SEL_HOLD, 1'b0, "final");
      @(posedge clk);
      #3;

      // Scoreboard must have drained
      checkValue("scoreboard drained", expQ.size(), 0);

      // Borrow case on the 3/5 instance with random serial input
      @(negedge clk);
      sel2 = SEL_LOAD;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checkValue("dut2 load A", int'(aOut2), 3);
            checkValue("dut2 load B", int'(bOut2), 5);
            checkValue("dut2 load Q", int'(qOut2), 1);
         end
         sel2  = SEL_SHR;
         si2   = 1'($urandom_range(0, 1));
         expB2 = {si2, expB2[3:1]};
      end
      @(negedge clk);
      sel2 = SEL_HOLD;
      #1;
      checkValue("dut2 difference", int'(aOut2), (3 - 5 + 16) % 16);
      checkValue("dut2 borrow", int'(qOut2), (3 >= 5) ? 1 : 0);
      checkValue("dut2 B serial", int'(bOut2), int'(expB2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
